acc_ctrl_unit: RTL and testbench
================================

Name: acc_ctrl_unit

Overview:
- Parametrised, clocked successor to the basic-computer accumulator. It holds AC (WIDTH bits) and the E (extend/carry) flip-flop.
- It decodes memory-reference, register-reference and I/O control gates internally and performs the selected micro-operation on the rising edge.
- It also produces skip-condition pulses, zero/sign status and a sticky illegal-combination flag.
- It sits between the control unit's timing/decode outputs and the common bus (DR, INPR).

Parameters:
- WIDTH, 16, AC/DR width; legal range is WIDTH >= 2.
- INPR_W, 8, input register width; legal range is 1 <= INPR_W <= WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- DR  in  WIDTH  data register operand.
- INPR  in  INPR_W  input character.
- D  in  8  one-hot opcode decode, D[0]..D[7].
- T5  in  1  timing signal for memory-reference execute.
- r  in  1  register-reference qualifier (D7·I'·T3).
- p  in  1  I/O qualifier (D7·I·T3).
- B  in  12  IR[11:0].
- AC  out  WIDTH  accumulator, registered.
- E  out  1  extend bit, registered.
- ZERO  out  1  AC == 0, combinational from the AC register.
- SIGN  out  1  AC[WIDTH-1].
- SKIP  out  1  one-cycle registered skip request.
- CONFLICT  out  1  sticky illegal-combination flag.

Behaviour:
- Reset:
  - RST=1 at an edge: AC=0, E=0, SKIP=0, CONFLICT=0.
  - Reset overrides every operation in the same cycle.
- Gates (combinational, evaluated each cycle):
  - AND = D[0]·T5; ADD = D[1]·T5; LDA = D[2]·T5.
  - CLA = r·B[11]; CLE = r·B[10]; CMA = r·B[9]; CME = r·B[8]; CIR = r·B[7]; CIL = r·B[6]; INC = r·B[5].
  - SPA = r·B[4]; SNA = r·B[3]; SZA = r·B[2]; SZE = r·B[1].
  - INP = p·B[11].
- AC writers, applied by priority CLA > AND > ADD > LDA > INP > CMA > CIR > CIL > INC:
  - CLA: AC <= 0.
  - AND: AC <= AC & DR.
  - ADD: {E,AC} <= AC + DR, a (WIDTH+1)-bit sum.
  - LDA: AC <= DR.
  - INP: AC[INPR_W-1:0] <= INPR; upper bits are unchanged.
  - CMA: AC <= ~AC.
  - CIR: {AC,E} rotate right: AC[WIDTH-1] <= E, E <= AC[0].
  - CIL: rotate left: AC[0] <= E, E <= AC[WIDTH-1].
  - INC: AC <= AC + 1, wraps modulo 2^WIDTH. E is unchanged.
- E writers, by priority CLE > CME > ADD > CIR > CIL:
  - CLE: E <= 0.
  - CME: E <= ~E.
  - ADD, CIR, CIL: as defined above.
  - An E-only op (CLE, CME) coexisting with an AC-only op is legal; both are applied.
- No gate active: AC and E hold.
- Skip:
  - SKIP <= (SPA·~AC[W-1]) | (SNA·AC[W-1]) | (SZA·(AC==0)) | (SZE·~E).
  - Conditions are evaluated on pre-edge values.
  - SKIP is high exactly one cycle after the gate cycle; skip ops never write AC or E.
- CONFLICT:
  - Set at the edge when more than one AC-writer is active, when more than one E-writer is active, or when any memory gate is active together with r or p.
  - The priority result is still applied in that cycle.
  - Cleared only by RST.
- Latency: one cycle for every operation. There are no multi-cycle states.
- Unknown inputs: X on an inactive gate's operand has no effect on AC.

Decomposition:
- Package acc_pkg holds:
  - Bit-index constants B_CLA=11, B_CLE=10, B_CMA=9, B_CME=8, B_CIR=7, B_CIL=6, B_INC=5, B_SPA=4, B_SNA=3, B_SZA=2, B_SZE=1, B_INP=11.
  - Opcode indices OP_AND=0, OP_ADD=1, OP_LDA=2.
  - An enum acc_op_e {NOP, CLA, AND, ADD, LDA, INP, CMA, CIR, CIL, INC} for the resolved AC operation.
- One sub-module, acc_alu (combinational):
  - Takes the resolved op, AC, E, DR and INPR.
  - Returns next AC and next E.
- Decode, priority, skip and conflict logic live in the top level.

Test Plan (WIDTH=16, INPR_W=8):
1. RST mid-operation:
   - AC=0x1234, E=1; assert RST together with D[1]·T5.
   - Next cycle AC=0, E=0, SKIP=0, CONFLICT=0.
2. ADD carry:
   - AC=0xFFFF, DR=0x0002, D[1]=T5=1 for one cycle.
   - Next cycle AC=0x0001, E=1, CONFLICT=0.
3. Rotate and increment wrap:
   - AC=0x8001, E=0; CIL gives AC=0x0002, E=1.
   - Then CIR gives AC=0x8001, E=0.
   - Then INC with AC=0xFFFF gives AC=0x0000, E=0, ZERO=1.
4. INP partial load:
   - AC=0xABCD, INPR=0x5A, p=1, B[11]=1.
   - Next cycle AC=0xAB5A.
5. Skip pulse:
   - AC=0x0000, r=1, B[2]=1 for one cycle.
   - SKIP=1 for exactly the following cycle, then 0. AC is unchanged.
   - Repeat with AC=0x8000 and SPA: SKIP stays 0.
6. Conflict:
   - r=1, B=0x220 (CMA+INC) with AC=0x00F0.
   - Next cycle AC=0xFF0F (CMA wins) and CONFLICT=1.
   - CONFLICT stays 1 through later clean ops until RST.

Source files
------------

// File: rtl/acc_ctrl_unit_pkg.sv
// Shared constants and the resolved-operation type for the accumulator unit.
// Bit positions refer to IR[11:0]; opcode indices refer to the one-hot decode D.
package acc_pkg;

  localparam int unsigned B_CLA = 11;
  localparam int unsigned B_CLE = 10;
  localparam int unsigned B_CMA = 9;
  localparam int unsigned B_CME = 8;
  localparam int unsigned B_CIR = 7;
  localparam int unsigned B_CIL = 6;
  localparam int unsigned B_INC = 5;
  localparam int unsigned B_SPA = 4;
  localparam int unsigned B_SNA = 3;
  localparam int unsigned B_SZA = 2;
  localparam int unsigned B_SZE = 1;
  localparam int unsigned B_INP = 11;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_LDA = 2;

  typedef enum logic [3:0] {
    NOP, CLA, AND, ADD, LDA, INP, CMA, CIR, CIL, INC
  } acc_op_e;

endpackage

// File: rtl/acc_ctrl_unit_if.sv
// Bundle of control-unit decode inputs, bus operands and accumulator status outputs.
// The master side drives timing/decode and operands; the slave side is the accumulator.
interface acc_ctrl_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned INPR_W = 8
);

  logic [WIDTH-1:0]  DR;
  logic [INPR_W-1:0] INPR;
  logic [7:0]        D;
  logic              T5;
  logic              r;
  logic              p;
  logic [11:0]       B;
  logic [WIDTH-1:0]  AC;
  logic              E;
  logic              ZERO;
  logic              SIGN;
  logic              SKIP;
  logic              CONFLICT;

  modport master (
    output DR, INPR, D, T5, r, p, B,
    input  AC, E, ZERO, SIGN, SKIP, CONFLICT
  );

  modport slave (
    input  DR, INPR, D, T5, r, p, B,
    output AC, E, ZERO, SIGN, SKIP, CONFLICT
  );

endinterface

// File: rtl/acc_ctrl_unit_alu.sv
// Combinational datapath: next AC from the winning AC operation and next E from the
// winning carry/rotate operation. CLE/CME are applied by the caller.
module acc_alu
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned INPR_W = 8
) (
  input  acc_op_e           op,
  input  acc_op_e           e_op,
  input  logic [WIDTH-1:0]  ac,
  input  logic              e,
  input  logic [WIDTH-1:0]  dr,
  input  logic [INPR_W-1:0] inpr,
  output logic [WIDTH-1:0]  ac_next,
  output logic              e_next
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, ac} + {1'b0, dr};

  always_comb begin
    ac_next = ac;
    case (op)
      CLA:     ac_next = '0;
      AND:     ac_next = ac & dr;
      ADD:     ac_next = sum[WIDTH-1:0];
      LDA:     ac_next = dr;
      INP:     ac_next[INPR_W-1:0] = inpr;
      CMA:     ac_next = ~ac;
      CIR:     ac_next = {e, ac[WIDTH-1:1]};
      CIL:     ac_next = {ac[WIDTH-2:0], e};
      INC:     ac_next = ac + {{(WIDTH-1){1'b0}}, 1'b1};
      default: ac_next = ac;
    endcase
  end

  always_comb begin
    e_next = e;
    case (e_op)
      ADD:     e_next = sum[WIDTH];
      CIR:     e_next = ac[0];
      CIL:     e_next = ac[WIDTH-1];
      default: e_next = e;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_unit.sv
// Accumulator/E register pair with gate decode, priority resolution, skip pulse and a
// sticky flag for illegal gate combinations.
module acc_ctrl_unit
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned INPR_W = 8
) (
  input logic           CLK,
  input logic           RST,
  acc_ctrl_unit_if.slave bus
);

  logic g_and, g_add, g_lda, g_inp;
  logic g_cla, g_cle, g_cma, g_cme, g_cir, g_cil, g_inc;
  logic g_spa, g_sna, g_sza, g_sze;
  logic [8:0] ac_wr;
  logic [4:0] e_wr;
  logic       conflict_now;
  logic       skip_d;

  acc_op_e          ac_op, e_op;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             e_q, e_d, e_alu;
  logic             skip_q, conflict_q;

  assign g_and = bus.D[OP_AND] & bus.T5;
  assign g_add = bus.D[OP_ADD] & bus.T5;
  assign g_lda = bus.D[OP_LDA] & bus.T5;
  assign g_inp = bus.p & bus.B[B_INP];
  assign g_cla = bus.r & bus.B[B_CLA];
  assign g_cle = bus.r & bus.B[B_CLE];
  assign g_cma = bus.r & bus.B[B_CMA];
  assign g_cme = bus.r & bus.B[B_CME];
  assign g_cir = bus.r & bus.B[B_CIR];
  assign g_cil = bus.r & bus.B[B_CIL];
  assign g_inc = bus.r & bus.B[B_INC];
  assign g_spa = bus.r & bus.B[B_SPA];
  assign g_sna = bus.r & bus.B[B_SNA];
  assign g_sza = bus.r & bus.B[B_SZA];
  assign g_sze = bus.r & bus.B[B_SZE];

  logic unused_inputs;
  assign unused_inputs = ^{bus.D[7:3], bus.B[0]};

  assign ac_wr = {g_cla, g_and, g_add, g_lda, g_inp, g_cma, g_cir, g_cil, g_inc};
  assign e_wr  = {g_cle, g_cme, g_add, g_cir, g_cil};

  assign conflict_now = ($countones(ac_wr) > 1) || ($countones(e_wr) > 1) ||
                        ((g_and | g_add | g_lda) & (bus.r | bus.p));

  always_comb begin
    ac_op = NOP;
    if (g_cla)      ac_op = CLA;
    else if (g_and) ac_op = AND;
    else if (g_add) ac_op = ADD;
    else if (g_lda) ac_op = LDA;
    else if (g_inp) ac_op = INP;
    else if (g_cma) ac_op = CMA;
    else if (g_cir) ac_op = CIR;
    else if (g_cil) ac_op = CIL;
    else if (g_inc) ac_op = INC;
  end

  // E has its own priority chain, so it may take a different source than AC on a conflict.
  always_comb begin
    e_op = NOP;
    if (g_add)      e_op = ADD;
    else if (g_cir) e_op = CIR;
    else if (g_cil) e_op = CIL;
  end

  acc_alu #(
    .WIDTH  (WIDTH),
    .INPR_W (INPR_W)
  ) u_alu (
    .op      (ac_op),
    .e_op    (e_op),
    .ac      (ac_q),
    .e       (e_q),
    .dr      (bus.DR),
    .inpr    (bus.INPR),
    .ac_next (ac_d),
    .e_next  (e_alu)
  );

  always_comb begin
    e_d = e_alu;
    if (g_cle)      e_d = 1'b0;
    else if (g_cme) e_d = ~e_q;
  end

  assign skip_d = (g_spa & ~ac_q[WIDTH-1]) | (g_sna & ac_q[WIDTH-1]) |
                  (g_sza & (ac_q == '0)) | (g_sze & ~e_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ac_q       <= '0;
      e_q        <= 1'b0;
      skip_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ac_q       <= ac_d;
      e_q        <= e_d;
      skip_q     <= skip_d;
      conflict_q <= conflict_q | conflict_now;
    end
  end

  assign bus.AC       = ac_q;
  assign bus.E        = e_q;
  assign bus.ZERO     = (ac_q == '0);
  assign bus.SIGN     = ac_q[WIDTH-1];
  assign bus.SKIP     = skip_q;
  assign bus.CONFLICT = conflict_q;

endmodule

// File: tb/tb_acc_ctrl_unit.sv
// Directed and randomized checks of acc_ctrl_unit against an arithmetic reference model.
module tb_acc_ctrl_unit;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [15:0] m_ac;
  logic        m_e, m_skip, m_conf;

  acc_ctrl_unit_if #(.WIDTH(16), .INPR_W(8)) bus ();

  acc_ctrl_unit #(.WIDTH(16), .INPR_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.D = 8'h00; bus.T5 = 1'b0; bus.r = 1'b0; bus.p = 1'b0;
    bus.B = 12'h000; bus.DR = 16'h0000; bus.INPR = 8'h00; rst = 1'b0;
  endtask

  // Reference: next state straight from the gate equations and priority lists.
  task automatic cycle();
    int ac, dr, inpr, n_ac, n_e, nac, sum;
    bit e, ne, nskip, nconf;
    bit a_and, a_add, a_lda, a_inp, a_cla, a_cle, a_cma, a_cme, a_cir, a_cil, a_inc;
    ac = int'(m_ac); e = m_e; dr = int'(bus.DR); inpr = int'(bus.INPR);
    a_and = bus.D[0] && bus.T5; a_add = bus.D[1] && bus.T5; a_lda = bus.D[2] && bus.T5;
    a_inp = bus.p && bus.B[11];
    a_cla = bus.r && bus.B[11]; a_cle = bus.r && bus.B[10]; a_cma = bus.r && bus.B[9];
    a_cme = bus.r && bus.B[8]; a_cir = bus.r && bus.B[7]; a_cil = bus.r && bus.B[6];
    a_inc = bus.r && bus.B[5];
    n_ac = a_cla + a_and + a_add + a_lda + a_inp + a_cma + a_cir + a_cil + a_inc;
    n_e  = a_cle + a_cme + a_add + a_cir + a_cil;
    nconf = m_conf || n_ac > 1 || n_e > 1 || ((a_and || a_add || a_lda) && (bus.r || bus.p));
    nskip = (bus.r && bus.B[4] && ac < 32768) || (bus.r && bus.B[3] && ac >= 32768) ||
            (bus.r && bus.B[2] && ac == 0) || (bus.r && bus.B[1] && !e);
    sum = ac + dr;
    if (a_cla)      nac = 0;
    else if (a_and) nac = ac & dr;
    else if (a_add) nac = sum % 65536;
    else if (a_lda) nac = dr;
    else if (a_inp) nac = (ac / 256) * 256 + inpr;
    else if (a_cma) nac = 65535 - ac;
    else if (a_cir) nac = int'(e) * 32768 + ac / 2;
    else if (a_cil) nac = (ac * 2) % 65536 + int'(e);
    else if (a_inc) nac = (ac + 1) % 65536;
    else            nac = ac;
    if (a_cle)      ne = 1'b0;
    else if (a_cme) ne = !e;
    else if (a_add) ne = (sum >= 65536);
    else if (a_cir) ne = (ac % 2) == 1;
    else if (a_cil) ne = (ac >= 32768);
    else            ne = e;
    if (rst) begin
      nac = 0; ne = 1'b0; nskip = 1'b0; nconf = 1'b0;
    end
    @(posedge clk);
    #1;
    m_ac = 16'(nac); m_e = ne; m_skip = nskip; m_conf = nconf;
    chk("ac", bus.AC, m_ac);
    chk("e", bus.E, m_e);
    chk("zero", bus.ZERO, m_ac == 16'h0);
    chk("sign", bus.SIGN, m_ac[15]);
    chk("skip", bus.SKIP, m_skip);
    chk("conflict", bus.CONFLICT, m_conf);
  endtask

  task automatic mem_op(input int idx, input logic [15:0] dr);
    idle(); bus.D = 8'(1 << idx); bus.T5 = 1'b1; bus.DR = dr; cycle();
  endtask

  task automatic reg_op(input logic [11:0] b);
    idle(); bus.r = 1'b1; bus.B = b; cycle();
  endtask

  initial begin
    m_ac = '0; m_e = 1'b0; m_skip = 1'b0; m_conf = 1'b0;
    idle(); rst = 1'b1;
    cycle();
    chk("reset_ac", bus.AC, 16'h0000);
    chk("reset_conf", bus.CONFLICT, 1'b0);

    // 1: reset wins over a same-cycle ADD
    mem_op(OP_LDA, 16'h1234);
    reg_op(12'h100);
    chk("preload_e", bus.E, 1'b1);
    idle(); bus.D = 8'h02; bus.T5 = 1'b1; bus.DR = 16'h1111; rst = 1'b1;
    cycle();
    chk("rst_mid_ac", bus.AC, 16'h0000);
    chk("rst_mid_e", bus.E, 1'b0);
    chk("rst_mid_skip", bus.SKIP, 1'b0);

    // 2: ADD carry out
    mem_op(OP_LDA, 16'hFFFF);
    mem_op(OP_ADD, 16'h0002);
    chk("add_ac", bus.AC, 16'h0001);
    chk("add_e", bus.E, 1'b1);
    chk("add_conf", bus.CONFLICT, 1'b0);

    // 3: rotates and INC wrap
    mem_op(OP_LDA, 16'h8001);
    reg_op(12'h400);
    reg_op(12'h040);
    chk("cil_ac", bus.AC, 16'h0002);
    chk("cil_e", bus.E, 1'b1);
    reg_op(12'h080);
    chk("cir_ac", bus.AC, 16'h8001);
    chk("cir_e", bus.E, 1'b0);
    mem_op(OP_LDA, 16'hFFFF);
    reg_op(12'h020);
    chk("inc_ac", bus.AC, 16'h0000);
    chk("inc_e", bus.E, 1'b0);
    chk("inc_zero", bus.ZERO, 1'b1);

    // 4: INP touches only the low byte
    mem_op(OP_LDA, 16'hABCD);
    idle(); bus.p = 1'b1; bus.B = 12'h800; bus.INPR = 8'h5A; cycle();
    chk("inp_ac", bus.AC, 16'hAB5A);

    // 5: skip pulse lasts one cycle; X on an unused DR is harmless
    reg_op(12'h800);
    idle(); bus.r = 1'b1; bus.B = 12'h004; bus.DR = 16'hxxxx; cycle();
    chk("sza_skip", bus.SKIP, 1'b1);
    chk("sza_ac", bus.AC, 16'h0000);
    idle(); cycle();
    chk("skip_drop", bus.SKIP, 1'b0);
    mem_op(OP_LDA, 16'h8000);
    reg_op(12'h010);
    chk("spa_neg", bus.SKIP, 1'b0);
    reg_op(12'h008);
    chk("sna_neg", bus.SKIP, 1'b1);

    // 6: sticky conflict, priority result still applied
    mem_op(OP_LDA, 16'h00F0);
    reg_op(12'h220);
    chk("conf_ac", bus.AC, 16'hFF0F);
    chk("conf_set", bus.CONFLICT, 1'b1);
    mem_op(OP_LDA, 16'h0042);
    reg_op(12'h020);
    chk("conf_sticky", bus.CONFLICT, 1'b1);
    idle(); rst = 1'b1; cycle();
    chk("conf_clear", bus.CONFLICT, 1'b0);

    // Random mix, mostly single legal ops with occasional multi-gate words and resets
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.DR = 16'($urandom); bus.INPR = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          bus.D = 8'(1 << $urandom_range(0, 7)); bus.T5 = ($urandom_range(0, 3) != 0);
        end
        1: bus.B = 12'(1 << $urandom_range(1, 11));
        2: bus.B = 12'h800;
        default: ;
      endcase
      if (bus.B != 12'h000) begin
        if (bus.B == 12'h800 && $urandom_range(0, 1) == 1) bus.p = 1'b1;
        else bus.r = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        bus.B = 12'($urandom); bus.r = 1'($urandom); bus.p = 1'($urandom);
      end
      rst = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
